// File: rtl/instr_fetch_ctrl_if.sv
// Interface bundling the loader, pipeline-control, instruction-memory and status
// signals of the instruction fetch controller.
interface instr_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  boot_skip_i;
  logic                  ld_valid_i;
  logic [DATA_WIDTH-1:0] ld_data_i;
  logic                  ld_done_i;
  logic                  ld_ready_o;
  logic                  stall_i;
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  logic [DATA_WIDTH-1:0] mem_q_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [31:0]           pc_o;
  logic [31:0]           pc_plus4_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  instr_valid_o;
  logic [1:0]            state_o;
  logic                  addr_err_o;

  modport slave (
    input  boot_skip_i, ld_valid_i, ld_data_i, ld_done_i, stall_i,
           redirect_i, redirect_pc_i, mem_q_i,
    output ld_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, pc_o, pc_plus4_o,
           instr_o, instr_valid_o, state_o, addr_err_o
  );

  modport master (
    output boot_skip_i, ld_valid_i, ld_data_i, ld_done_i, stall_i,
           redirect_i, redirect_pc_i, mem_q_i,
    input  ld_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, pc_o, pc_plus4_o,
           instr_o, instr_valid_o, state_o, addr_err_o
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: boots, optionally loads program memory from a
// streaming loader, then fetches with zero-cycle latency until an address fault.
module instr_fetch_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] PC_BASE    = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [32:0]           MEM_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
  logic                  addr_err_q, addr_err_d;

  logic [31:0] pc_off;
  logic        pc_bad;

  assign pc_off = pc_q - PC_BASE;
  // Misaligned, below the base, or past the end of the instruction memory.
  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q < PC_BASE) ||
                  ({1'b0, pc_off} >= MEM_BYTES);

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    ld_cnt_d          = ld_cnt_q;
    addr_err_d        = addr_err_q;
    bus.ld_ready_o    = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = pc_off[ADDR_WIDTH+1:2];
    bus.instr_o       = '0;
    bus.instr_valid_o = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_d     = PC_BASE;
        ld_cnt_d = '0;
        state_d  = bus.boot_skip_i ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        bus.ld_ready_o = 1'b1;
        bus.mem_addr_o = ld_cnt_q;
        if (bus.ld_valid_i) begin
          bus.mem_we_o = 1'b1;
          ld_cnt_d     = ld_cnt_q + 1'b1;
        end
        // The last memory word ends the load so the counter never wraps onto word 0.
        if (bus.ld_done_i || (bus.ld_valid_i && (ld_cnt_q == LAST_ADDR))) begin
          state_d = ST_RUN;
          pc_d    = PC_BASE;
        end
      end
      ST_RUN: begin
        bus.instr_o = bus.mem_q_i;
        if (pc_bad) begin
          addr_err_d = 1'b1;
          state_d    = ST_HALT;
        end else begin
          bus.instr_valid_o = !bus.redirect_i;
          if (bus.redirect_i) begin
            pc_d = bus.redirect_pc_i;
          end else if (!bus.stall_i) begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= PC_BASE;
      ld_cnt_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ld_cnt_q   <= ld_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.mem_wdata_o = bus.ld_data_i;
  assign bus.pc_o        = pc_q;
  assign bus.pc_plus4_o  = pc_q + 32'd4;
  assign bus.state_o     = state_q;
  assign bus.addr_err_o  = addr_err_q;

endmodule
